scr1_dmi_chain_ctrl: RTL and testbench

SysCLK-domain DMI scan-chain controller. It consumes the single-cycle capture/shift/update/tdi qualifiers produced by the TAPC synchronizer and returns TDO to it. It implements the DTMCS and DMI-access data registers, and runs the request/response handshake to the Debug Module. It sits between the TAPC synchronizer and the DM in the debug subsystem.

---
 rtl/scr1_dmi_chain_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_scr1_dmi_chain_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_dmi_chain_ctrl.sv
// scr1_dmi_chain_ctrl
// SysCLK-domain DMI scan-chain controller. Decodes the synchronized TAP
// capture/shift/update qualifiers for the DTMCS (id 1) and DMI-access (id 2)
// data registers, drives TDO, and issues request/response transactions to
// the Debug Module.
//
// Optional feature: define SCR1_DBG_DMI_TIMEOUT_EN to abort a DM access that
// stays outstanding for TIMEOUT cycles (dmistat becomes 2, "failed").
//
// DM handshake: dmi_req is the request valid. The request and its payload
// (op/addr/wdata) stay stable while dmi_req=1. The request completes on the
// clock edge where dmi_req=1 and dmi_req_ack=1 are sampled together. The DM
// then answers with a single-cycle dmi_resp strobe, no earlier than the cycle
// after ack, and dmi_resp_rdata is valid only while dmi_resp=1.

`ifndef SCR1_DBG_DMI_CH_ID_WIDTH
`define SCR1_DBG_DMI_CH_ID_WIDTH 2
`endif

module scr1_dmi_chain_ctrl #(
  parameter int ABITS   = 7,
  parameter int TIMEOUT = 255
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 dmi_ch_sel_core,
  input  logic [`SCR1_DBG_DMI_CH_ID_WIDTH-1:0] dmi_ch_id_core,
  input  logic                                 dmi_ch_capture_core,
  input  logic                                 dmi_ch_shift_core,
  input  logic                                 dmi_ch_update_core,
  input  logic                                 dmi_ch_tdi_core,
  output logic                                 dmi_ch_tdo_core,
  output logic                                 dmi_req,
  output logic [1:0]                           dmi_req_op,
  output logic [ABITS-1:0]                     dmi_req_addr,
  output logic [31:0]                          dmi_req_wdata,
  input  logic                                 dmi_req_ack,
  input  logic                                 dmi_resp,
  input  logic [31:0]                          dmi_resp_rdata,
  output logic [1:0]                           dbg_fsm_state
);

  localparam int SR_W = ABITS + 34;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } dmi_state_e;

  dmi_state_e        state;
  dmi_state_e        state_next;
  logic [SR_W-1:0]   sr;
  logic [SR_W-1:0]   sr_shift;
  logic [1:0]        dmistat;
  logic [ABITS-1:0]  last_addr;
  logic [31:0]       last_rdata;
  logic [1:0]        cap_op;
  logic [31:0]       dtmcs_cap;

  logic              ch_active;
  logic              is_dtmcs;
  logic              ev_update;
  logic              ev_capture;
  logic              ev_shift;
  logic              dtmcs_upd;
  logic              dmi_upd;
  logic              dmi_cap;
  logic              hard_rst;
  logic              dmi_accept;
  logic              busy;
  logic              timeout_hit;

  logic [ABITS-1:0]  upd_addr;
  logic [31:0]       upd_data;
  logic [1:0]        upd_op;

  assign upd_addr = sr[SR_W-1:34];
  assign upd_data = sr[33:2];
  assign upd_op   = sr[1:0];

  // Event decode: only a selected chain with a known id reacts; update wins
  // over capture, capture wins over shift.
  always_comb begin
    ch_active  = dmi_ch_sel_core &&
                 ((dmi_ch_id_core == `SCR1_DBG_DMI_CH_ID_WIDTH'(1)) ||
                  (dmi_ch_id_core == `SCR1_DBG_DMI_CH_ID_WIDTH'(2)));
    is_dtmcs   = (dmi_ch_id_core == `SCR1_DBG_DMI_CH_ID_WIDTH'(1));
    ev_update  = ch_active && dmi_ch_update_core;
    ev_capture = ch_active && dmi_ch_capture_core && !dmi_ch_update_core;
    ev_shift   = ch_active && dmi_ch_shift_core && !dmi_ch_update_core &&
                 !dmi_ch_capture_core;
    dtmcs_upd  = ev_update && is_dtmcs;
    dmi_upd    = ev_update && !is_dtmcs;
    dmi_cap    = ev_capture && !is_dtmcs;
    hard_rst   = dtmcs_upd && sr[17];
    busy       = (state != ST_IDLE);
    dmi_accept = dmi_upd && (dmistat == 2'd0) && !busy &&
                 ((upd_op == 2'd1) || (upd_op == 2'd2));
  end

  // Capture values and the shifted register image for the active chain.
  always_comb begin
    dtmcs_cap = {17'b0, 3'd1, dmistat, 6'(ABITS), 4'd1};
    if (dmistat != 2'd0) begin
      cap_op = dmistat;
    end else if (busy) begin
      cap_op = 2'd3;
    end else begin
      cap_op = 2'd0;
    end
    sr_shift = sr >> 1;
    if (is_dtmcs) begin
      sr_shift[31] = dmi_ch_tdi_core;
    end else begin
      sr_shift[SR_W-1] = dmi_ch_tdi_core;
    end
  end

`ifdef SCR1_DBG_DMI_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] tmo_cnt;

  // Access age counter: held at zero in IDLE, counts every REQ/WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (!busy || state_next == ST_IDLE) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign timeout_hit = busy && (tmo_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state; hard reset and timeout abort any access in flight.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (dmi_accept)  state_next = ST_REQ;
      ST_REQ:  if (dmi_req_ack) state_next = ST_WAIT;
      ST_WAIT: if (dmi_resp)    state_next = ST_IDLE;
      default:                  state_next = ST_IDLE;
    endcase
    if (hard_rst || timeout_hit) begin
      state_next = ST_IDLE;
    end
  end

  assign dmi_req       = (state == ST_REQ);
  assign dbg_fsm_state = state;

  // Scan register and registered TDO (TDO trails sr[0] by one cycle).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr              <= '0;
      dmi_ch_tdo_core <= 1'b0;
    end else begin
      dmi_ch_tdo_core <= sr[0];
      if (ev_capture) begin
        if (is_dtmcs) begin
          sr <= {{(SR_W-32){1'b0}}, dtmcs_cap};
        end else begin
          sr <= {last_addr, last_rdata, cap_op};
        end
      end else if (ev_shift) begin
        sr <= sr_shift;
      end
    end
  end

  // Sticky dmistat: set by timeout (failed) or overlapping access (busy),
  // cleared only by DTMCS dmireset/dmihardreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmistat <= 2'd0;
    end else if (timeout_hit) begin
      dmistat <= 2'd2;
    end else if (dtmcs_upd && (sr[16] || sr[17])) begin
      dmistat <= 2'd0;
    end else if ((dmi_cap || dmi_upd) && (dmistat == 2'd0) && busy) begin
      dmistat <= 2'd3;
    end
  end

  // Request payload: latched on an accepted update, stable until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmi_req_op    <= 2'd0;
      dmi_req_addr  <= '0;
      dmi_req_wdata <= 32'd0;
    end else if (dmi_accept) begin
      dmi_req_op    <= upd_op;
      dmi_req_addr  <= upd_addr;
      dmi_req_wdata <= upd_data;
    end
  end

  // Completed-access record returned by the next DMI capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_addr  <= '0;
      last_rdata <= 32'd0;
    end else if ((state == ST_WAIT) && dmi_resp && !hard_rst && !timeout_hit) begin
      last_addr  <= dmi_req_addr;
      last_rdata <= dmi_resp_rdata;
    end
  end

endmodule

// File: tb/tb_scr1_dmi_chain_ctrl.sv
// Testbench for scr1_dmi_chain_ctrl: directed scans of the DTMCS and DMI
// chains with hand-computed expected values (ABITS=7).
`timescale 1ns/1ps

module tb_scr1_dmi_chain_ctrl;

`ifdef SCR1_DBG_DMI_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ch_sel = 1'b0;
  logic [1:0]  ch_id = 2'd0;
  logic        ch_capture = 1'b0;
  logic        ch_shift = 1'b0;
  logic        ch_update = 1'b0;
  logic        ch_tdi = 1'b0;
  logic        ch_tdo;
  logic        req;
  logic [1:0]  req_op;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata;
  logic        req_ack = 1'b0;
  logic        resp = 1'b0;
  logic [31:0] resp_rdata = 32'd0;
  logic [1:0]  fsm_state;

  scr1_dmi_chain_ctrl #(.ABITS(7), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .dmi_ch_sel_core     (ch_sel),
    .dmi_ch_id_core      (ch_id),
    .dmi_ch_capture_core (ch_capture),
    .dmi_ch_shift_core   (ch_shift),
    .dmi_ch_update_core  (ch_update),
    .dmi_ch_tdi_core     (ch_tdi),
    .dmi_ch_tdo_core     (ch_tdo),
    .dmi_req             (req),
    .dmi_req_op          (req_op),
    .dmi_req_addr        (req_addr),
    .dmi_req_wdata       (req_wdata),
    .dmi_req_ack         (req_ack),
    .dmi_resp            (resp),
    .dmi_resp_rdata      (resp_rdata),
    .dbg_fsm_state       (fsm_state)
  );

  // Scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d,
                                           input logic [1:0] op);
    return {23'b0, a, d, op};
  endfunction

  // Driver tasks: inputs change 1ns after the rising edge, outputs sampled there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dr_capture(input logic [1:0] id);
    ch_sel = 1'b1;
    ch_id = id;
    ch_capture = 1'b1;
    tick();
    ch_capture = 1'b0;
  endtask

  task automatic dr_shift(input int len, input logic [63:0] din, output logic [63:0] dout);
    dout = '0;
    for (int i = 0; i < len; i++) begin
      ch_tdi = din[i];
      ch_shift = 1'b1;
      tick();
      dout[i] = ch_tdo;
    end
    ch_shift = 1'b0;
    ch_tdi = 1'b0;
  endtask

  task automatic dr_update();
    ch_update = 1'b1;
    tick();
    ch_update = 1'b0;
  endtask

  task automatic scan(input logic [1:0] id, input logic [63:0] din, output logic [63:0] dout);
    dr_capture(id);
    dr_shift((id == 2'd1) ? 32 : 41, din, dout);
    dr_update();
  endtask

  task automatic do_ack();
    req_ack = 1'b1;
    tick();
    req_ack = 1'b0;
  endtask

  task automatic do_resp(input logic [31:0] rd);
    resp = 1'b1;
    resp_rdata = rd;
    tick();
    resp = 1'b0;
    resp_rdata = 32'd0;
  endtask

  // Scans whose shifted-out word is compared against the head of exp_q.
  task automatic scan_chk(input string tag, input logic [1:0] id, input logic [63:0] din);
    logic [63:0] dout;
    scan(id, din, dout);
    if (exp_q.size() == 0) begin
      check({tag, "_noexp"}, 64'd1, 64'd0);
    end else begin
      check(tag, dout, exp_q.pop_front());
    end
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tdo", 64'(ch_tdo), 64'd0);
    check("rst_req", 64'(req), 64'd0);
    check("rst_op", 64'(req_op), 64'd0);
    check("rst_addr", 64'(req_addr), 64'd0);
    check("rst_wdata", 64'(req_wdata), 64'd0);
    check("rst_state", 64'(fsm_state), 64'd0);
    rst_n = 1'b1;
    tick();

    // DTMCS after reset: version 1, abits 7, dmistat 0, idle 1
    exp_q.push_back(64'h1071);
    scan_chk("dtmcs_rst", 2'd1, 64'd0);

    // Write 0xDEADBEEF to 0x10, ack after 3 cycles
    exp_q.push_back(dmi_word(7'h00, 32'h0, 2'd0));
    scan_chk("dmi_cap0", 2'd2, dmi_word(7'h10, 32'hDEADBEEF, 2'd2));
    check("wr_req", 64'(req), 64'd1);
    check("wr_op", 64'(req_op), 64'd2);
    check("wr_addr", 64'(req_addr), 64'h10);
    check("wr_wdata", 64'(req_wdata), 64'hDEADBEEF);
    repeat (3) tick();
    check("wr_req_hold", 64'(req), 64'd1);
    check("wr_wdata_hold", 64'(req_wdata), 64'hDEADBEEF);
    do_ack();
    check("wr_req_drop", 64'(req), 64'd0);
    check("wr_state_wait", 64'(fsm_state), 64'd2);
    do_resp(32'hCAFE0001);
    check("wr_state_idle", 64'(fsm_state), 64'd0);

    // Read 0x11; capture shows the completed write
    exp_q.push_back(dmi_word(7'h10, 32'hCAFE0001, 2'd0));
    scan_chk("dmi_cap_wr", 2'd2, dmi_word(7'h11, 32'h0, 2'd1));
    check("rd_req", 64'(req), 64'd1);
    check("rd_op", 64'(req_op), 64'd1);
    check("rd_addr", 64'(req_addr), 64'h11);
    do_ack();
    do_resp(32'h12345678);
    // op=0 update is a no-operation
    exp_q.push_back(dmi_word(7'h11, 32'h12345678, 2'd0));
    scan_chk("dmi_cap_rd", 2'd2, dmi_word(7'h7F, 32'hFFFFFFFF, 2'd0));
    check("nop_req", 64'(req), 64'd0);
    check("nop_state", 64'(fsm_state), 64'd0);

`ifndef SCR1_DBG_DMI_TIMEOUT_EN
    // Busy: capture during WAIT
    exp_q.push_back(dmi_word(7'h11, 32'h12345678, 2'd0));
    scan_chk("dmi_cap_rd2", 2'd2, dmi_word(7'h12, 32'h0, 2'd1));
    do_ack();
    exp_q.push_back(dmi_word(7'h11, 32'h12345678, 2'd3));
    scan_chk("dmi_cap_busy", 2'd2, dmi_word(7'h13, 32'h0, 2'd1));
    check("busy_no_req", 64'(req), 64'd0);
    check("busy_state", 64'(fsm_state), 64'd2);
    exp_q.push_back(64'h1C71);
    scan_chk("dtmcs_busy", 2'd1, 64'h0001_0000);
    exp_q.push_back(64'h1071);
    scan_chk("dtmcs_cleared", 2'd1, 64'd0);
    do_resp(32'h0BADF00D);
    check("busy_idle", 64'(fsm_state), 64'd0);
    exp_q.push_back(dmi_word(7'h12, 32'h0BADF00D, 2'd0));
    scan_chk("dmi_cap_after_clr", 2'd2, dmi_word(7'h13, 32'h0, 2'd1));
    check("retry_req", 64'(req), 64'd1);
    check("retry_addr", 64'(req_addr), 64'h13);
    do_ack();
    do_resp(32'h600DCAFE);

    // dmihardreset during REQ
    exp_q.push_back(dmi_word(7'h13, 32'h600DCAFE, 2'd0));
    scan_chk("dmi_cap_hr", 2'd2, dmi_word(7'h14, 32'h55, 2'd2));
    check("hr_req_before", 64'(req), 64'd1);
    exp_q.push_back(64'h1071);
    scan_chk("dtmcs_hr", 2'd1, 64'h0002_0000);
    check("hr_req_drop", 64'(req), 64'd0);
    check("hr_state", 64'(fsm_state), 64'd0);
    do_resp(32'hFFFFFFFF);
    exp_q.push_back(dmi_word(7'h13, 32'h600DCAFE, 2'd0));
    scan_chk("dmi_cap_late_resp", 2'd2, 64'd0);
`endif

    // Asynchronous reset in the middle of an access
    dr_capture(2'd2);
    begin
      logic [63:0] dummy;
      dr_shift(41, dmi_word(7'h15, 32'h1234, 2'd2), dummy);
    end
    dr_update();
    check("ar_req_before", 64'(req), 64'd1);
    do_ack();
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_req", 64'(req), 64'd0);
    check("ar_state", 64'(fsm_state), 64'd0);
    check("ar_tdo", 64'(ch_tdo), 64'd0);
    check("ar_wdata", 64'(req_wdata), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_resp(32'hDEAD0000);
    exp_q.push_back(dmi_word(7'h00, 32'h0, 2'd0));
    scan_chk("dmi_cap_after_rst", 2'd2, 64'd0);

`ifdef SCR1_DBG_DMI_TIMEOUT_EN
    // Request never acked: aborted after TIMEOUT cycles
    exp_q.push_back(dmi_word(7'h00, 32'h0, 2'd0));
    scan_chk("dmi_cap_tmo", 2'd2, dmi_word(7'h16, 32'h0, 2'd1));
    n = 0;
    while (req && n < 50) begin
      n++;
      tick();
    end
    check("tmo_req_cycles", 64'(n), 64'd8);
    check("tmo_state", 64'(fsm_state), 64'd0);
    exp_q.push_back(64'h1871);
    scan_chk("dtmcs_tmo", 2'd1, 64'h0001_0000);
    exp_q.push_back(64'h1071);
    scan_chk("dtmcs_tmo_clr", 2'd1, 64'd0);
`else
    n = 0;
`endif

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
